// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: mode encodings, start patterns,
// speed-level width and the prescaler counter width.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ModeShl    = 2'd0,
    ModeShr    = 2'd1,
    ModeFill   = 2'd2,
    ModeBounce = 2'd3
  } mode_e;

  localparam int unsigned SpeedW = 2;
  // Wide enough to hold a period of 2^26.
  localparam int unsigned CntW   = 27;

  localparam logic [7:0] StartShl    = 8'h01;
  localparam logic [7:0] StartShr    = 8'h80;
  localparam logic [7:0] StartFill   = 8'h00;
  localparam logic [7:0] StartBounce = 8'h01;

  function automatic logic [7:0] start_pattern(input mode_e m);
    logic [7:0] p;
    unique case (m)
      ModeShl:    p = StartShl;
      ModeShr:    p = StartShr;
      ModeFill:   p = StartFill;
      ModeBounce: p = StartBounce;
      default:    p = StartShl;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..period-1 while run is high and strobes tick on the
// last count. clr restarts the count from 0 regardless of run.
module tick_prescaler
  import led_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rs,
  input  logic            run,
  input  logic            clr,
  input  logic [CntW-1:0] period,
  output logic            tick
);

  logic [CntW-1:0] count_q, count_d;

  assign tick = run && (count_q == period - CntW'(1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mode FSM, pattern register and button edge detection, stepping
// on a prescaled tick whose period halves with each speed level.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              btn_mode,
  input  logic              btn_speed,
  input  logic              run,
  output logic [7:0]        led,
  output logic [1:0]        mode,
  output logic [SpeedW-1:0] speed,
  output logic              tick
);

  mode_e             mode_q, mode_d;
  logic [7:0]        led_q, led_d;
  logic [SpeedW-1:0] speed_q, speed_d;
  logic              dir_left_q, dir_left_d;
  logic              btn_mode_q, btn_speed_q;
  logic              mode_edge, speed_edge;
  logic [CntW-1:0]   period;

  assign mode_edge  = btn_mode & ~btn_mode_q;
  assign speed_edge = btn_speed & ~btn_speed_q;
  assign period     = CntW'(TICK_DIV) >> speed_q;

  tick_prescaler u_prescaler (
    .clk    (clk),
    .rs     (rs),
    .run    (run),
    .clr    (mode_edge | speed_edge),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    speed_d    = speed_q;
    dir_left_d = dir_left_q;

    if (speed_edge) begin
      speed_d = speed_q + SpeedW'(1);
    end

    // A mode change takes priority over a pattern step in the same cycle.
    if (mode_edge) begin
      unique case (mode_q)
        ModeShl:    mode_d = ModeShr;
        ModeShr:    mode_d = ModeFill;
        ModeFill:   mode_d = ModeBounce;
        ModeBounce: mode_d = ModeShl;
        default:    mode_d = ModeShl;
      endcase
      led_d      = start_pattern(mode_d);
      dir_left_d = 1'b1;
    end else if (tick) begin
      unique case (mode_q)
        ModeShl:  led_d = {led_q[6:0], led_q[7]};
        ModeShr:  led_d = {led_q[0], led_q[7:1]};
        ModeFill: led_d = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
        ModeBounce: begin
          led_d = dir_left_q ? {led_q[6:0], 1'b0} : {1'b0, led_q[7:1]};
          if (led_d == 8'h80) begin
            dir_left_d = 1'b0;
          end else if (led_d == 8'h01) begin
            dir_left_d = 1'b1;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  // Button history resets to 1 so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    if (rs) begin
      mode_q      <= ModeShl;
      led_q       <= StartShl;
      speed_q     <= '0;
      dir_left_q  <= 1'b1;
      btn_mode_q  <= 1'b1;
      btn_speed_q <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      led_q       <= led_d;
      speed_q     <= speed_d;
      dir_left_q  <= dir_left_d;
      btn_mode_q  <= btn_mode;
      btn_speed_q <= btn_speed;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl at TICK_DIV=8: directed vector table plus randomized run
// against a step-index reference model.
module tb_led_seq_ctrl;

  localparam int unsigned TickDiv = 8;

  logic       clk = 1'b0;
  logic       rs, btn_mode, btn_speed, run;
  logic [7:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       tick;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: mode, speed, prescaler count and steps taken since the mode's start.
  int m_mode, m_speed, m_cnt, m_k;
  bit m_pbm, m_pbs;

  typedef struct {
    bit         rs;
    bit         bm;
    bit         bs;
    bit         rn;
    int         n;
    logic [7:0] led;
    logic [1:0] md;
    logic [1:0] sp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  led_seq_ctrl #(.TICK_DIV(TickDiv)) dut (
    .clk       (clk),
    .rs        (rs),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .run       (run),
    .led       (led),
    .mode      (mode),
    .speed     (speed),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Pattern after k steps from the start of mode md.
  function automatic logic [7:0] pat(input int md, input int k);
    int p;
    case (md)
      0:       return 8'(1 << (k % 8));
      1:       return 8'(128 >> (k % 8));
      2:       return 8'((1 << (k % 9)) - 1);
      default: begin
        p = k % 14;
        return (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {led,mode,speed,tick}=%h expected %h at %0t", name, act, exp,
                  $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_cnt = 0; m_k = 0; m_pbm = 1'b1; m_pbs = 1'b1;
  endtask

  // One clock cycle: drive, check against model at negedge, advance model, step past posedge.
  task automatic cyc(input bit r, input bit bm, input bit bs, input bit rn);
    int p;
    bit t, me, se;
    rs = r; btn_mode = bm; btn_speed = bs; run = rn;
    @(negedge clk);
    p = TickDiv >> m_speed;
    t = rn && (m_cnt == p - 1);
    check("cycle", {led, mode, speed, tick},
          {pat(m_mode, m_k), 2'(m_mode), 2'(m_speed), t});
    if (r) begin
      model_reset();
    end else begin
      me = bm && !m_pbm;
      se = bs && !m_pbs;
      if (me) begin
        m_mode = (m_mode + 1) % 4;
        m_k    = 0;
      end else if (t) begin
        m_k++;
      end
      if (se) m_speed = (m_speed + 1) % 4;
      if (me || se) m_cnt = 0;
      else if (rn) m_cnt = t ? 0 : m_cnt + 1;
      m_pbm = bm;
      m_pbs = bs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, input bit bm, input bit bs, input bit rn, input int n,
                     input logic [7:0] l, input logic [1:0] md, input logic [1:0] sp,
                     input string name);
    vec_t v;
    v.rs = r; v.bm = bm; v.bs = bs; v.rn = rn; v.n = n;
    v.led = l; v.md = md; v.sp = sp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    bit r, bm, bs, rn;

    rs = 1'b1; btn_mode = 1'b0; btn_speed = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    //  rs bm bs rn  n    led    mode  spd
    add(1, 0, 0, 0,   2, 8'h01, 2'd0, 2'd0, "reset");
    add(0, 0, 0, 1,   7, 8'h01, 2'd0, 2'd0, "pre_first_tick");
    add(0, 0, 0, 1,   1, 8'h02, 2'd0, 2'd0, "first_tick");
    add(0, 0, 0, 1,  48, 8'h80, 2'd0, 2'd0, "shl_80");
    add(0, 0, 0, 1,   8, 8'h01, 2'd0, 2'd0, "shl_wrap");
    add(0, 0, 1, 1,   1, 8'h01, 2'd0, 2'd1, "speed_1");
    add(0, 0, 1, 1,   4, 8'h02, 2'd0, 2'd1, "p4_tick_held_btn");
    add(0, 0, 0, 1,   1, 8'h02, 2'd0, 2'd1, "speed_held");
    add(0, 0, 1, 0,   1, 8'h02, 2'd0, 2'd2, "speed_2_frozen");
    add(0, 0, 0, 0,   1, 8'h02, 2'd0, 2'd2, "speed_rel");
    add(0, 0, 1, 0,   1, 8'h02, 2'd0, 2'd3, "speed_3");
    add(0, 0, 0, 0,   1, 8'h02, 2'd0, 2'd3, "speed_rel2");
    add(0, 0, 1, 0,   1, 8'h02, 2'd0, 2'd0, "speed_wrap");
    add(0, 0, 0, 1,   7, 8'h02, 2'd0, 2'd0, "p8_pre");
    add(0, 0, 0, 1,   1, 8'h04, 2'd0, 2'd0, "p8_tick");
    add(0, 1, 0, 0,   1, 8'h80, 2'd1, 2'd0, "mode_shr");
    add(0, 0, 0, 0,   1, 8'h80, 2'd1, 2'd0, "mode_rel");
    add(0, 1, 0, 0,   1, 8'h00, 2'd2, 2'd0, "mode_fill");
    add(0, 0, 0, 1,   8, 8'h01, 2'd2, 2'd0, "fill_01");
    add(0, 0, 0, 1,  56, 8'hFF, 2'd2, 2'd0, "fill_ff");
    add(0, 0, 0, 1,   8, 8'h00, 2'd2, 2'd0, "fill_wrap");
    add(0, 1, 0, 0,   1, 8'h01, 2'd3, 2'd0, "mode_bounce");
    add(0, 0, 0, 1,  56, 8'h80, 2'd3, 2'd0, "bounce_top");
    add(0, 0, 0, 1,  72, 8'h04, 2'd3, 2'd0, "bounce_16");
    add(0, 0, 0, 1,   3, 8'h04, 2'd3, 2'd0, "mid_count");
    add(0, 0, 0, 0,  20, 8'h04, 2'd3, 2'd0, "frozen");
    add(0, 0, 0, 1,   4, 8'h04, 2'd3, 2'd0, "resume_pre");
    add(0, 0, 0, 1,   1, 8'h08, 2'd3, 2'd0, "resume_tick");
    add(0, 0, 0, 1,   7, 8'h08, 2'd3, 2'd0, "to_tick_cycle");
    add(0, 1, 0, 1,   1, 8'h01, 2'd0, 2'd0, "mode_on_tick");
    add(1, 1, 0, 1,   2, 8'h01, 2'd0, 2'd0, "reset_btn_held");
    add(0, 1, 0, 1,   3, 8'h01, 2'd0, 2'd0, "no_edge_after_rel");
    add(0, 0, 0, 1,   5, 8'h02, 2'd0, 2'd0, "tick_p_after_rel");

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) cyc(vecs[i].rs, vecs[i].bm, vecs[i].bs, vecs[i].rn);
      check(vecs[i].name, {led, mode, speed, 1'b0}, {vecs[i].led, vecs[i].md, vecs[i].sp, 1'b0});
    end

    // Mid-count reset while animating.
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_count_reset", {led, mode, speed, tick}, {8'h01, 2'd0, 2'd0, 1'b0});

    bm = 1'b0; bs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(63) == 0);
      rn = ($urandom_range(7) != 0);
      if ($urandom_range(9) == 0) bm = ~bm;
      if ($urandom_range(11) == 0) bs = ~bs;
      cyc(r, bm, bs, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
